// File: rtl/uart_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader_if
// Brief    : Byte write port from the UART program loader into instruction memory.
// Revision : 1.0
// ============================================================================
interface uart_prog_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_we;

    modport master (output prog_addr, output prog_data, output prog_we);
    modport slave  (input  prog_addr, input  prog_data, input  prog_we);
endinterface
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Brief    : UART 8N1 receiver plus frame loader that writes a program image
//            into instruction memory and holds the core in reset until it validates.
// Revision : 1.0
// ============================================================================
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 217,
    parameter int          ADDR_W       = 5,
    parameter int          DATA_W       = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_BITS = 64
) (
    input  wire logic            i_Clk,
    input  wire logic            i_Rst_n,
    input  wire logic            i_Rx,
    uart_prog_loader_if.master   prog,
    output logic                 o_Cpu_Rst,
    output logic                 o_Done,
    output logic                 o_Err
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int LEN_W   = ADDR_W + 1;
    localparam int MAX_LEN = 2 ** ADDR_W;
    localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W    = $clog2(TO_CLKS);

    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  C_TO   = TO_W'(TO_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_SYNC, L_LEN, L_DATA, L_CSUM, L_RUN} ld_state_t;

    // ---------------- RX front end ----------------
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d  = '0;
                bit_idx_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == C_HALF) begin
                    rx_cnt_d   = '0;
                    // A line that is high again at mid-bit was only a glitch.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == C_FULL) begin
                    rx_cnt_d  = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == C_FULL) begin
                    rx_state_d  = RX_IDLE;
                    rx_valid_d  = rx_sync_q;
                    frame_err_d = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= i_Rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------- Loader FSM ----------------
    ld_state_t         state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d, err_q, err_d, done_q, done_d, cpu_rst_q, cpu_rst_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic              in_frame, timeout, abort;

    assign in_frame = (state_q == L_LEN) || (state_q == L_DATA) || (state_q == L_CSUM);
    assign timeout  = in_frame && (timer_q == C_TO);
    assign abort    = frame_err_q || timeout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        err_d   = err_q;
        timer_d = (rx_valid_q || !in_frame) ? '0 : timer_q + 1'b1;
        case (state_q)
            L_SYNC, L_RUN: begin
                if (rx_valid_q && shift_q == SYNC_BYTE) begin
                    state_d = L_LEN;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            L_LEN: begin
                if (rx_valid_q) begin
                    if (shift_q == 8'd0 || int'(shift_q) > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = L_SYNC;
                    end else begin
                        len_d   = LEN_W'(shift_q);
                        sum_d   = shift_q;
                        state_d = L_DATA;
                    end
                end else if (abort) begin
                    err_d   = 1'b1;
                    state_d = L_SYNC;
                end
            end
            L_DATA: begin
                if (rx_valid_q) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q[ADDR_W-1:0];
                    data_d = DATA_W'(shift_q);
                    sum_d  = sum_q + shift_q;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) state_d = L_CSUM;
                end else if (abort) begin
                    err_d   = 1'b1;
                    state_d = L_SYNC;
                end
            end
            L_CSUM: begin
                if (rx_valid_q) begin
                    if (shift_q == sum_q) begin
                        state_d = L_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = L_SYNC;
                    end
                end else if (abort) begin
                    err_d   = 1'b1;
                    state_d = L_SYNC;
                end
            end
            default: state_d = L_SYNC;
        endcase
        // Core release and done both track entry into / exit from L_RUN one cycle later.
        cpu_rst_d = (state_d != L_RUN);
        done_d    = (state_d == L_RUN);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= L_SYNC;
            cnt_q     <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            err_q     <= err_d;
            done_q    <= done_d;
            cpu_rst_q <= cpu_rst_d;
            timer_q   <= timer_d;
        end
    end

    assign prog.prog_addr = addr_q;
    assign prog.prog_data = data_q;
    assign prog.prog_we   = we_q;
    assign o_Cpu_Rst      = cpu_rst_q;
    assign o_Done         = done_q;
    assign o_Err          = err_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_prog_loader
// Brief    : Directed self-checking bench for uart_prog_loader.
// Revision : 1.0
// ============================================================================
module tb_uart_prog_loader;
    localparam int CPB = 16;
    localparam int TOB = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic cpu_rst, done, err;

    always #5 clk = ~clk;

    uart_prog_loader_if #(.ADDR_W(5), .DATA_W(8)) prog ();

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB), .ADDR_W(5), .DATA_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(TOB)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx(rx), .prog(prog),
        .o_Cpu_Rst(cpu_rst), .o_Done(done), .o_Err(err)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         wr_total = 0;
    int         base     = 0;
    logic [7:0] mem_m [32];
    logic [4:0] last_addr;

    always @(negedge clk) begin
        if (prog.prog_we) begin
            mem_m[prog.prog_addr] <= prog.prog_data;
            last_addr             <= prog.prog_addr;
            wr_total              <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_we",      32'(prog.prog_we), 32'd0);
        check("rst_addr",    32'(prog.prog_addr), 32'd0);
        check("rst_data",    32'(prog.prog_data), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_err",     32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);

        // Valid 3-word frame
        base = wr_total;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        check("t1_writes", 32'(wr_total - base), 32'd3);
        check("t1_mem0", 32'(mem_m[0]), 32'h11);
        check("t1_mem1", 32'(mem_m[1]), 32'h22);
        check("t1_mem2", 32'(mem_m[2]), 32'h33);
        check("t1_last_addr", 32'(last_addr), 32'd2);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // Reload while running
        base = wr_total;
        send_byte(8'hA5);
        check("t5_cpu_rst_sync", 32'(cpu_rst), 32'd1);
        check("t5_done_sync", 32'(done), 32'd0);
        send_byte(8'h01); send_byte(8'h44); send_byte(8'h45);
        check("t5_writes", 32'(wr_total - base), 32'd1);
        check("t5_mem0", 32'(mem_m[0]), 32'h44);
        check("t5_mem1_kept", 32'(mem_m[1]), 32'h22);
        check("t5_done", 32'(done), 32'd1);
        check("t5_cpu_rst", 32'(cpu_rst), 32'd0);

        // Bad checksum
        base = wr_total;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'h00);
        check("t2_writes", 32'(wr_total - base), 32'd2);
        check("t2_mem0", 32'(mem_m[0]), 32'h10);
        check("t2_mem1", 32'(mem_m[1]), 32'h20);
        check("t2_mem2_kept", 32'(mem_m[2]), 32'h33);
        check("t2_err", 32'(err), 32'd1);
        check("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t2_done", 32'(done), 32'd0);

        // Illegal lengths, then recovery
        base = wr_total;
        send_byte(8'hA5);
        check("t3_err_clr0", 32'(err), 32'd0);
        send_byte(8'h00);
        check("t3_len0_err", 32'(err), 32'd1);
        send_byte(8'hA5);
        check("t3_err_clr1", 32'(err), 32'd0);
        send_byte(8'h21);
        check("t3_len33_err", 32'(err), 32'd1);
        check("t3_writes", 32'(wr_total - base), 32'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
        check("t3_recover_err", 32'(err), 32'd0);
        check("t3_recover_done", 32'(done), 32'd1);
        check("t3_mem0", 32'(mem_m[0]), 32'h07);

        // Framing error on second data byte
        base = wr_total;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        send_byte(8'h22, 1'b0);
        check("t4_frame_err", 32'(err), 32'd1);
        check("t4_frame_writes", 32'(wr_total - base), 32'd1);
        check("t4_frame_cpu_rst", 32'(cpu_rst), 32'd1);

        // Mid-frame stall
        base = wr_total;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        check("t4_pre_stall_err", 32'(err), 32'd0);
        repeat (TOB * CPB + 20) @(posedge clk);
        @(negedge clk);
        check("t4_timeout_err", 32'(err), 32'd1);
        check("t4_timeout_writes", 32'(wr_total - base), 32'd1);
        check("t4_timeout_done", 32'(done), 32'd0);

        // Reset mid data byte
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h5A); send_byte(8'h6B);
        check("t6_pre_data", 32'(prog.prog_data), 32'h6B);
        check("t6_pre_addr", 32'(prog.prog_addr), 32'd1);
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t6_rst_we", 32'(prog.prog_we), 32'd0);
        check("t6_rst_addr", 32'(prog.prog_addr), 32'd0);
        check("t6_rst_data", 32'(prog.prog_data), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_err", 32'(err), 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);

        // One-cycle glitch inside a frame produces no byte
        base = wr_total;
        send_byte(8'hA5);
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        @(negedge clk);
        check("t6_glitch_err", 32'(err), 32'd0);
        check("t6_glitch_writes", 32'(wr_total - base), 32'd0);
        send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h7A);
        check("t6_final_writes", 32'(wr_total - base), 32'd2);
        check("t6_final_mem0", 32'(mem_m[0]), 32'hAB);
        check("t6_final_mem1", 32'(mem_m[1]), 32'hCD);
        check("t6_final_done", 32'(done), 32'd1);
        check("t6_final_cpu_rst", 32'(cpu_rst), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
